mul_share_arb: RTL and testbench

// - Shares one sequential signed shift-add multiplier (`mul`, WIDTH-bit, one bit per cycle) between NREQ requesters.
// - Arbitrates round-robin, latches the winner's operands and sequences the multiplier's start/busy/done.
// - Returns the 2*WIDTH-bit product with the requester ID on a single valid/ready response channel.
// - Sits between the affinex peripheral register front-ends and the multiplier datapath.

---
 rtl/mul_share_arb.sv | 238 +++++++++++++++++++++++
 tb/tb_mul_share_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// Shares one sequential signed shift-add multiplier between NREQ requesters with a valid/ready response.
// Define MUL_SHARE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.

module mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic                 run_q, run_d;
    logic                 done_q, done_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   ma_q, ma_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mb_q, mb_d;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic neg, input logic [2*WIDTH-1:0] m);
        return neg ? (~m + 1'b1) : m;
    endfunction

    always_comb begin
        run_d  = run_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        ma_d   = ma_q;
        acc_d  = acc_q;
        mb_d   = mb_q;
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            acc_d = '0;
            ma_d  = {{WIDTH{1'b0}}, mag(a_i)};
            mb_d  = mag(b_i);
        end else if (run_q) begin
            // One extra cycle after the last bit so done lands WIDTH+1 cycles after start.
            if (cnt_q == CW'(WIDTH)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                if (mb_q[0]) begin
                    acc_d = acc_q + ma_q;
                end
                ma_d  = ma_q << 1;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            ma_q   <= '0;
            acc_q  <= '0;
            mb_q   <= '0;
        end else begin
            run_q  <= run_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            ma_q   <= ma_d;
            acc_q  <= acc_d;
            mb_q   <= mb_d;
        end
    end

    assign done     = done_q;
    assign result_o = apply_sign(a_i[WIDTH-1] ^ b_i[WIDTH-1], acc_q);
endmodule

module mul_share_arb #(
    parameter  int WIDTH = 16,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESP} state_t;

    state_t                        state_q, state_d;
    logic signed [WIDTH-1:0]       op_a_q, op_a_d;
    logic signed [WIDTH-1:0]       op_b_q, op_b_d;
    logic [IDW-1:0]                id_q, id_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]                rsp_id_q, rsp_id_d;
    logic signed [2*WIDTH-1:0]     rsp_result_q, rsp_result_d;
    logic                          gnt_vld;
    logic [IDW-1:0]                gnt_idx;
    logic [NREQ-1:0]               ready_c;
    logic                          mul_start;
    logic                          mul_done;
    logic [2*WIDTH-1:0]            mul_result;

`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    int             idx;

    // Search upward from rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_vld && req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        ready_c      = '0;
        mul_start    = 1'b0;
`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    ready_c[gnt_idx] = rst_n;
                    op_a_d  = req_a[gnt_idx*WIDTH +: WIDTH];
                    op_b_d  = req_b[gnt_idx*WIDTH +: WIDTH];
                    id_d    = gnt_idx;
                    state_d = ISSUE;
`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                if (mul_done) begin
                    rsp_result_d = mul_result;
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    mul #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mul_start),
        .a_i      (op_a_q),
        .b_i      (op_b_q),
        .done     (mul_done),
        .result_o (mul_result)
    );

    assign req_ready  = ready_c;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: scoreboard of expected id/product, immediate-assertion checks.

module tb_mul_share_arb;
    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = $clog2(NREQ);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*WIDTH-1:0]  req_a;
    logic [NREQ*WIDTH-1:0]  req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [2*WIDTH-1:0]     rsp_result;
    logic                   busy;

    typedef struct {
        int          id;
        logic [31:0] res;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    mul_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic push(input int id, input logic signed [15:0] a, input logic signed [15:0] b);
        logic signed [31:0] p;
        p = a * b;
        sbq.push_back('{id, p});
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"},  req_ready,  0);
        check({tag, "_rsp_valid"},  rsp_valid,  0);
        check({tag, "_rsp_id"},     rsp_id,     0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_busy"},       busy,       0);
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero(tag);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Returns at accept edge + 1; the accepted requester drops its valid there.
    task automatic do_accept(input int exp_idx, input string tag, output int waited);
        int n   = 0;
        int idx = -1;
        bit got = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got = 1;
                check({tag, "_onehot"}, $onehot(req_ready), 1);
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
            end else begin
                @(posedge clk);
                n++;
            end
        end
        waited = n;
        if (!got) begin
            check({tag, "_accept_timeout"}, 0, 1);
            return;
        end
        check({tag, "_grant"}, idx, exp_idx);
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
    endtask

    // Leaves the bench at the negedge where rsp_valid is first seen.
    task automatic do_rsp(input string tag);
        int   n   = 0;
        bit   got = 0;
        exp_t e;
        while (!got && n < 80) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        if (!got) begin
            check({tag, "_rsp_timeout"}, 0, 1);
            return;
        end
        check({tag, "_latency"}, n, WIDTH + 3);
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sbq.pop_front();
        check({tag, "_id"},     rsp_id,     e.id);
        check({tag, "_result"}, rsp_result, e.res);
        check({tag, "_busy"},   busy,       1);
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, rsp_valid, 0);
    endtask

    initial begin
        int          w;
        int          bv, br, bq;
        logic [31:0] hold;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Single request
        do_reset("rst0");
        set_req(0, 16'sd3, -16'sd5);
        push(0, 16'sd3, -16'sd5);
        do_accept(0, "single", w);
        do_rsp("single");
        check("single_const", rsp_result, 32'hFFFF_FFF1);
        consume("single");

        // Round-robin across all four
        do_reset("rst1");
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 16'(i + 1), 16'sd10);
            push(i, 16'(i + 1), 16'sd10);
        end
        for (int k = 0; k < NREQ; k++) begin
            do_accept(k, $sformatf("rr%0d", k), w);
            do_rsp($sformatf("rr%0d", k));
            consume($sformatf("rr%0d", k));
        end

        // Backpressure with another request pending
        do_reset("rst2");
        set_req(2, 16'sd32767, 16'sd32767);
        push(2, 16'sd32767, 16'sd32767);
        do_accept(2, "bp", w);
        do_rsp("bp");
        hold = rsp_result;
        set_req(0, -16'sd7, 16'sd9);
        push(0, -16'sd7, 16'sd9);
        bv = 0; br = 0; bq = 0;
        repeat (50) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid !== 1'b1)  bv++;
            if (rsp_result !== hold) br++;
            if (req_ready !== '0)    bq++;
        end
        check("bp_valid_held",  bv, 0);
        check("bp_result_held", br, 0);
        check("bp_ready_low",   bq, 0);
        check("bp_const", rsp_result, 32'h3FFF_0001);
        consume("bp");
        do_accept(0, "bp_next", w);
        check("bp_next_b2b", w, 0);
        do_rsp("bp_next");
        consume("bp_next");

        // Operand change after accept, second request waits for handshake
        do_reset("rst3");
        set_req(1, -16'sd1, -16'sd1);
        push(1, -16'sd1, -16'sd1);
        set_req(3, 16'sd5, -16'sd6);
        push(3, 16'sd5, -16'sd6);
        do_accept(1, "opchg", w);
        req_a[1*WIDTH +: WIDTH] = 16'sd100;
        req_b[1*WIDTH +: WIDTH] = -16'sd100;
        do_rsp("opchg");
        check("opchg_ready_hold", req_ready, 0);
        consume("opchg");
        do_accept(3, "opchg_next", w);
        check("opchg_next_b2b", w, 0);
        do_rsp("opchg_next");
        consume("opchg_next");

        // Reset in the middle of RUN
        do_reset("rst4");
        set_req(0, 16'sd1234, -16'sd3);
        do_accept(0, "midrst", w);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_zero("midrst_held");
        @(posedge clk);
        #1 rst_n = 1'b1;
        bv = 0; bq = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bv++;
            if (busy !== 1'b0)      bq++;
            @(posedge clk);
        end
        check("midrst_no_rsp",  bv, 0);
        check("midrst_no_busy", bq, 0);
        #1;
        set_req(1, -16'sd300, 16'sd200);
        push(1, -16'sd300, 16'sd200);
        do_accept(1, "postrst", w);
        do_rsp("postrst");
        consume("postrst");
        check("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
